// File: rtl/payload_frame_loader.sv
// payload_frame_loader: loads length-prefixed UART frames into the payload FIFO and emits a length descriptor
module payload_frame_loader #(
    parameter int          DEPTH          = 256,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_wr_data,
    input  logic [8:0] fifo_free,
    input  logic       fifo_full,
    output logic       desc_valid,
    output logic [8:0] desc_len,
    output logic       desc_err,
    input  logic       desc_ready,
    output logic       busy,
    output logic       err_timeout
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [8:0] MAX_LEN = 9'(DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT_SPACE, PAYLOAD, PAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [8:0]      len_q, len_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            desc_valid_q, desc_valid_d;
    logic [8:0]      desc_len_q, desc_len_d;
    logic            desc_err_q, desc_err_d;

    assign busy       = (state_q != IDLE);
    assign desc_valid = desc_valid_q;
    assign desc_len   = desc_len_q;
    assign desc_err   = desc_err_q;

    // Next-state and output decode; a byte handshake beats a coincident timeout.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        err_d        = err_q;
        desc_valid_d = desc_valid_q && !desc_ready;
        desc_len_d   = desc_len_q;
        desc_err_d   = desc_err_q;
        rx_ready     = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = rx_data;
        err_timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                rx_ready = !rst;
                if (rx_valid && rx_ready) begin
                    len_d   = (rx_data == 8'd0) ? MAX_LEN : {1'b0, rx_data};
                    err_d   = 1'b0;
                    state_d = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (fifo_free >= len_q) begin
                    cnt_d   = 9'd0;
                    timer_d = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                rx_ready = !fifo_full;
                if (rx_valid && rx_ready) begin
                    fifo_wr_en = 1'b1;
                    cnt_d      = cnt_q + 9'd1;
                    timer_d    = '0;
                    if (cnt_q == len_q - 9'd1) state_d = DONE;
                end else if (TIMEOUT_CYCLES != 0 && timer_q == T_LIM) begin
                    err_timeout = 1'b1;
                    err_d       = 1'b1;
                    state_d     = PAD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PAD: begin
                fifo_wr_en   = !fifo_full;
                fifo_wr_data = PAD_BYTE;
                if (!fifo_full) begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == len_q - 9'd1) state_d = DONE;
                end
            end
            DONE: begin
                if (!desc_valid_q || desc_ready) begin
                    desc_valid_d = 1'b1;
                    desc_len_d   = len_q;
                    desc_err_d   = err_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and descriptor registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= 9'd0;
            cnt_q        <= 9'd0;
            timer_q      <= '0;
            err_q        <= 1'b0;
            desc_valid_q <= 1'b0;
            desc_len_q   <= 9'd0;
            desc_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            desc_valid_q <= desc_valid_d;
            desc_len_q   <= desc_len_d;
            desc_err_q   <= desc_err_d;
        end
    end
endmodule

// File: tb/tb_payload_frame_loader.sv
// tb_payload_frame_loader: randomized frames checked against a queue-based scoreboard
module tb_payload_frame_loader;
    localparam int TO = 8;
    localparam logic [7:0] PADB = 8'h5A;

    logic       clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, fifo_full = 1'b0, desc_ready;
    logic [7:0] rx_data = 8'd0;
    logic [8:0] fifo_free = 9'd256;
    logic       rx_ready, fifo_wr_en, desc_valid, desc_err, busy, err_timeout;
    logic [7:0] fifo_wr_data;
    logic [8:0] desc_len;

    int checks = 0, failures = 0;
    int cyc = 0, last_pw = 0, cur_len = 0, exp_to = 0, to_seen = 0, dr_mode = 1;
    bit space_ok = 0, prev_hold = 0;
    logic [9:0] prev_d;
    logic [7:0] exp_w[$];
    logic [9:0] exp_d[$];
    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    logic [9:0] d_log[$];
    int         d_cyc[$];

    payload_frame_loader #(.DEPTH(256), .TIMEOUT_CYCLES(TO), .PAD_BYTE(PADB)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_free(fifo_free),
        .fifo_full(fifo_full), .desc_valid(desc_valid), .desc_len(desc_len),
        .desc_err(desc_err), .desc_ready(desc_ready), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        desc_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            desc_ready = (dr_mode == 2) ? ($urandom_range(0, 3) != 0) : (dr_mode == 1);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            space_ok  = 0;
            prev_hold = 0;
        end else begin
            if (!busy) chk_eq("idle_rx_ready", rx_ready, 1);
            if (rx_valid && rx_ready && !busy) begin
                cur_len  = (rx_data == 8'd0) ? 256 : int'(rx_data);
                space_ok = 0;
            end
            if (busy && int'(fifo_free) >= cur_len) space_ok = 1;
            if (busy && !space_ok) begin
                chk_eq("space_wait_rx_ready", rx_ready, 0);
                chk_eq("space_wait_write", fifo_wr_en, 0);
            end
            if (busy && fifo_full) chk_eq("full_rx_ready", rx_ready, 0);
            if (fifo_wr_en) begin
                chk_eq("write_while_full", fifo_full, 0);
                wr_log.push_back(fifo_wr_data);
                wr_cyc.push_back(cyc);
                if (rx_valid && rx_ready) last_pw = cyc;
                if (exp_w.size() == 0) chk_eq("extra_write", fifo_wr_en, 0);
                else chk_eq("write_data", fifo_wr_data, exp_w.pop_front());
            end
            if (err_timeout) begin
                to_seen++;
                chk_eq("timeout_delay", cyc - last_pw, TO);
            end
            if (prev_hold) begin
                chk_eq("desc_hold_valid", desc_valid, 1);
                chk_eq("desc_hold_data", {desc_err, desc_len}, prev_d);
            end
            if (desc_valid && desc_ready) begin
                d_log.push_back({desc_err, desc_len});
                d_cyc.push_back(cyc);
                if (exp_d.size() == 0) chk_eq("extra_desc", desc_valid, 0);
                else chk_eq("desc_err_len", {desc_err, desc_len}, exp_d.pop_front());
            end
            prev_hold = desc_valid && !desc_ready;
            prev_d    = {desc_err, desc_len};
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit h = 0;
        int n = 0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        while (!h && n < 3000) begin
            @(negedge clk);
            h = rx_ready;
            tick();
            n++;
        end
        rx_valid = 1'b0;
        chk_eq("rx_handshake", h, 1);
    endtask

    task automatic frame(input int n, input int k, input bit to, input int base, input int gmax, input bit stall);
        logic [7:0] b;
        fifo_free = stall ? 9'($urandom_range(0, n - 1)) : (base >= 0 ? 9'd256 : 9'($urandom_range(n, 256)));
        exp_d.push_back({to, 9'(n)});
        send_byte(8'(n), $urandom_range(0, gmax));
        if (stall) begin
            repeat ($urandom_range(1, 20)) tick();
            fifo_free = 9'($urandom_range(n, 256));
        end
        for (int i = 0; i < k; i++) begin
            b = (base < 0) ? 8'($urandom) : 8'(base + i);
            exp_w.push_back(b);
            send_byte(b, $urandom_range(0, gmax));
        end
        if (to) begin
            for (int i = k; i < n; i++) exp_w.push_back(PADB);
            exp_to++;
            repeat (TO + n - k + 4) tick();
        end
    endtask

    task automatic drain;
        int n = 0;
        dr_mode = 1;
        while ((busy || desc_valid || exp_d.size() != 0) && n < 5000) begin
            tick();
            n++;
        end
        chk_eq("drain_bound", int'(n < 5000), 1);
    endtask

    task automatic clear_logs;
        wr_log.delete();
        wr_cyc.delete();
        d_log.delete();
        d_cyc.delete();
    endtask

    initial begin
        int bad, n, k;
        bit to;
        @(negedge clk);
        chk_eq("rst_rx_ready", rx_ready, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_desc_valid", desc_valid, 0);
        chk_eq("rst_desc_len", desc_len, 0);
        chk_eq("rst_desc_err", desc_err, 0);
        chk_eq("rst_err_timeout", err_timeout, 0);
        chk_eq("rst_wr_en", fifo_wr_en, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_rx_ready", rx_ready, 1);
        tick();

        // nominal three-byte frame
        clear_logs();
        frame(3, 3, 0, 'hA1, 0, 0);
        drain();
        chk_eq("nom_count", wr_log.size(), 3);
        chk_eq("nom_b0", wr_log[0], 8'hA1);
        chk_eq("nom_b1", wr_log[1], 8'hA2);
        chk_eq("nom_b2", wr_log[2], 8'hA3);
        chk_eq("nom_desc", d_log[0], 10'd3);
        chk_eq("nom_desc_latency", d_cyc[0] - wr_cyc[2], 2);
        chk_eq("nom_busy_after", busy, 0);

        // space stall: LEN=10 with only 5 free for 20 cycles
        clear_logs();
        exp_d.push_back(10'd10);
        fifo_free = 9'd5;
        send_byte(8'd10, 0);
        rx_data  = 8'h30;
        rx_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rx_ready || fifo_wr_en) bad++;
            tick();
        end
        chk_eq("stall_quiet", bad, 0);
        chk_eq("stall_writes", wr_log.size(), 0);
        fifo_free = 9'd10;
        for (int i = 0; i < 10; i++) begin
            exp_w.push_back(8'(8'h30 + i));
            send_byte(8'(8'h30 + i), 0);
        end
        drain();
        chk_eq("stall_count", wr_log.size(), 10);
        chk_eq("stall_desc", d_log[0], 10'd10);

        // LEN=0 encodes a 256-byte frame
        clear_logs();
        frame(256, 256, 0, 0, 0, 0);
        drain();
        chk_eq("max_count", wr_log.size(), 256);
        chk_eq("max_last", wr_log[255], 8'hFF);
        chk_eq("max_desc", d_log[0], 10'd256);

        // timeout after 2 of 4 bytes, then a normal frame
        clear_logs();
        frame(4, 2, 1, 'hC1, 0, 0);
        frame(2, 2, 0, 'hD1, 0, 0);
        drain();
        chk_eq("to_count", wr_log.size(), 6);
        chk_eq("to_pad0", wr_log[2], PADB);
        chk_eq("to_pad1", wr_log[3], PADB);
        chk_eq("to_next", wr_log[4], 8'hD1);
        chk_eq("to_desc", d_log[0], 10'h204);
        chk_eq("to_next_desc", d_log[1], 10'd2);
        chk_eq("to_pulses", to_seen, 1);

        // descriptor back-pressure
        clear_logs();
        dr_mode = 0;
        frame(1, 1, 0, 'h11, 0, 0);
        frame(1, 1, 0, 'h22, 0, 0);
        repeat (5) tick();
        @(negedge clk);
        chk_eq("bp_valid", desc_valid, 1);
        chk_eq("bp_desc", {desc_err, desc_len}, 10'd1);
        chk_eq("bp_busy", busy, 1);
        chk_eq("bp_rx_ready", rx_ready, 0);
        chk_eq("bp_no_handshake", d_log.size(), 0);
        tick();
        dr_mode = 1;
        repeat (4) tick();
        chk_eq("bp_desc_count", d_log.size(), 2);
        chk_eq("bp_back_to_back", d_cyc[1] - d_cyc[0], 1);
        chk_eq("bp_data", wr_log[1], 8'h22);

        // fifo_full gates payload acceptance
        drain();
        exp_d.push_back(10'd2);
        fifo_free = 9'd256;
        send_byte(8'd2, 0);
        exp_w.push_back(8'h61);
        send_byte(8'h61, 0);
        exp_w.push_back(8'h62);
        fifo_full = 1'b1;
        rx_data   = 8'h62;
        rx_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_eq("full_gate", rx_ready, 0);
            tick();
        end
        fifo_full = 1'b0;
        send_byte(8'h62, 0);
        drain();

        // asynchronous reset in the middle of a payload
        exp_w.push_back(8'h71);
        send_byte(8'd5, 0);
        send_byte(8'h71, 0);
        #2 rst = 1'b1;
        #1;
        chk_eq("arst_rx_ready", rx_ready, 0);
        chk_eq("arst_desc_valid", desc_valid, 0);
        chk_eq("arst_busy", busy, 0);
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_eq("arst_idle_ready", rx_ready, 1);
        tick();
        frame(3, 3, 0, -1, 3, 0);
        drain();

        // randomized frames
        dr_mode = 2;
        repeat (40) begin
            n  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 256) : $urandom_range(1, 12);
            to = (n >= 2) && ($urandom_range(0, 4) == 0);
            k  = to ? $urandom_range(1, n - 1) : n;
            frame(n, k, to, -1, $urandom_range(0, TO - 1), $urandom_range(0, 3) == 0);
        end
        drain();
        chk_eq("left_writes", exp_w.size(), 0);
        chk_eq("left_descs", exp_d.size(), 0);
        chk_eq("timeout_pulses", to_seen, exp_to);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
